// File: rtl/div1024_arbiter_if.sv
// rtl/div1024_arbiter_if.sv - requester, response and div1024 RAM signal bundle for div1024_arbiter
interface div1024_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
);
    logic                    arb_en;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]       rsp_data;
    logic                    busy;
    logic [ADDR_W-1:0]       ram_addr;
    logic                    ram_wr_en;
    logic [DATA_W-1:0]       ram_rd_data;

    modport master (
        input  arb_en, req_valid, req_addr, ram_rd_data,
        output req_ready, rsp_valid, rsp_data, busy, ram_addr, ram_wr_en
    );

    modport slave (
        output arb_en, req_valid, req_addr, ram_rd_data,
        input  req_ready, rsp_valid, rsp_data, busy, ram_addr, ram_wr_en
    );
endinterface

// File: rtl/div1024_arbiter.sv
// rtl/div1024_arbiter.sv - round-robin arbiter sharing the div1024 reciprocal RAM, one lookup per clock
// Define DIV_ARB_RAM_OREG_EN when div1024 has its output register enabled (adds one response stage).
module div1024_arbiter #(
    parameter int N_REQ    = 4,
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 16,
    parameter int INIT_CYC = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    div1024_arbiter_if.master bus
);

`ifdef DIV_ARB_RAM_OREG_EN
    localparam int STAGES = 3;
`else
    localparam int STAGES = 2;
`endif
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {S_WAIT, S_RUN, S_DRAIN, S_IDLE} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [7:0]         init_cnt;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   ptr_nxt;
    logic [STAGES-1:0]  pipe_vld;
    logic [PTR_W-1:0]   pipe_tag [STAGES];
    logic [DATA_W-1:0]  data_q;
    logic               grant_any;
    logic [PTR_W-1:0]   grant_idx;
    logic [PTR_W:0]     idx_sum;
    logic               handshake;

    // Search starts at rr_ptr and wraps; first valid requester wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = rr_ptr;
        idx_sum   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx_sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (idx_sum >= (PTR_W+1)'(N_REQ)) begin
                idx_sum = idx_sum - (PTR_W+1)'(N_REQ);
            end
            if (!grant_any && bus.req_valid[idx_sum[PTR_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = idx_sum[PTR_W-1:0];
            end
        end
    end

    assign handshake = (state == S_RUN) && bus.arb_en && grant_any;
    assign ptr_nxt   = (grant_idx == PTR_W'(N_REQ-1)) ? '0 : grant_idx + 1'b1;

    always_comb begin
        bus.req_ready = '0;
        if (handshake) begin
            bus.req_ready = N_REQ'(1) << grant_idx;
        end
    end

    // Response data is taken straight from the RAM in its valid cycle and held afterwards.
    always_comb begin
        bus.rsp_valid = '0;
        bus.rsp_data  = data_q;
        if (pipe_vld[STAGES-1]) begin
            bus.rsp_valid = N_REQ'(1) << pipe_tag[STAGES-1];
            bus.rsp_data  = bus.ram_rd_data;
        end
    end

    assign bus.ram_wr_en = 1'b0;
    assign bus.busy      = (state == S_WAIT) || (state == S_DRAIN) || (|pipe_vld) || handshake;

    // DRAIN leaves on the edge where the final lookup leaves the last stage.
    always_comb begin
        state_nxt = state;
        case (state)
            S_WAIT: begin
                if (init_cnt == 8'(INIT_CYC-1)) begin
                    state_nxt = bus.arb_en ? S_RUN : S_IDLE;
                end
            end
            S_RUN: begin
                if (!bus.arb_en) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (~|pipe_vld[STAGES-2:0]) begin
                    state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                if (bus.arb_en) begin
                    state_nxt = S_RUN;
                end
            end
            default: state_nxt = S_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_WAIT;
            init_cnt     <= '0;
            rr_ptr       <= '0;
            pipe_vld     <= '0;
            data_q       <= '0;
            bus.ram_addr <= '0;
            for (int s = 0; s < STAGES; s++) begin
                pipe_tag[s] <= '0;
            end
        end else begin
            state       <= state_nxt;
            init_cnt    <= (state == S_WAIT) ? init_cnt + 1'b1 : '0;
            pipe_vld    <= {pipe_vld[STAGES-2:0], handshake};
            pipe_tag[0] <= grant_idx;
            for (int s = 1; s < STAGES; s++) begin
                pipe_tag[s] <= pipe_tag[s-1];
            end
            if (pipe_vld[STAGES-1]) begin
                data_q <= bus.ram_rd_data;
            end
            if (handshake) begin
                bus.ram_addr <= bus.req_addr[grant_idx*ADDR_W +: ADDR_W];
                rr_ptr       <= ptr_nxt;
            end
        end
    end

endmodule

// File: tb/tb_div1024_arbiter.sv
// tb/tb_div1024_arbiter.sv - directed bench for div1024_arbiter with ROM-backed RAM model and cycle-level scoreboard
`timescale 1ns/1ps
module tb_div1024_arbiter;

    localparam int N_REQ    = 4;
    localparam int ADDR_W   = 10;
    localparam int DATA_W   = 16;
    localparam int INIT_CYC = 8;
`ifdef DIV_ARB_RAM_OREG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    localparam int M_WAIT  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;
    localparam int M_IDLE  = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    div1024_arbiter_if #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    div1024_arbiter #(
        .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .INIT_CYC(INIT_CYC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom(input logic [9:0] a);
        rom = ({6'b0, a} * 16'd3) ^ 16'h1234;
    endfunction

    // div1024 stand-in: synchronous read, optional output register
    logic [15:0] ram_q;
    logic [15:0] ram_q2;
    always @(posedge clk) begin
        ram_q  <= rom(bus.ram_addr);
        ram_q2 <= ram_q;
    end
`ifdef DIV_ARB_RAM_OREG_EN
    assign bus.ram_rd_data = ram_q2;
`else
    assign bus.ram_rd_data = ram_q;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    typedef struct {
        int          tag;
        logic [9:0]  addr;
        int          due;
    } item_t;

    item_t       q[$];
    int          mode = M_WAIT;
    int          wcnt = 0;
    int          rr = 0;
    int          cycle = 0;
    logic [9:0]  last_addr = '0;

    always @(negedge clk) begin
        logic [3:0] e_ready;
        logic [3:0] e_rspv;
        logic       e_busy;
        bit         hs;
        bit         rsp_now;
        int         w;
        int         i;
        e_ready = '0;
        e_rspv  = '0;
        hs      = 1'b0;
        rsp_now = 1'b0;
        w       = 0;
        if (!rst_n) begin
            chk("rst_req_ready", bus.req_ready, 0);
            chk("rst_rsp_valid", bus.rsp_valid, 0);
            chk("rst_rsp_data", bus.rsp_data, 0);
            chk("rst_busy", bus.busy, 1);
            chk("rst_ram_addr", bus.ram_addr, 0);
            mode = M_WAIT;
            wcnt = 0;
            rr = 0;
            last_addr = '0;
            q.delete();
        end else begin
            if (mode == M_RUN && bus.arb_en) begin
                for (int k = 0; k < N_REQ; k++) begin
                    i = (rr + k) % N_REQ;
                    if (!hs && bus.req_valid[i]) begin
                        hs = 1'b1;
                        w = i;
                    end
                end
            end
            if (hs) e_ready[w] = 1'b1;
            rsp_now = (q.size() > 0) && (q[0].due == cycle);
            if (rsp_now) e_rspv[q[0].tag] = 1'b1;
            e_busy = (mode == M_WAIT) || (mode == M_DRAIN) || (q.size() > 0) || hs;

            chk("req_ready", bus.req_ready, e_ready);
            chk("rsp_valid", bus.rsp_valid, e_rspv);
            if (rsp_now) chk("rsp_data", bus.rsp_data, rom(q[0].addr));
            chk("busy", bus.busy, e_busy);
            chk("ram_addr", bus.ram_addr, last_addr);
            chk("ram_wr_en", bus.ram_wr_en, 0);

            if (rsp_now) void'(q.pop_front());
            if (hs) begin
                last_addr = bus.req_addr[w*ADDR_W +: ADDR_W];
                q.push_back('{tag: w, addr: last_addr, due: cycle + LAT});
                rr = (w + 1) % N_REQ;
            end
            case (mode)
                M_WAIT: begin
                    wcnt++;
                    if (wcnt == INIT_CYC) mode = bus.arb_en ? M_RUN : M_IDLE;
                end
                M_RUN:   if (!bus.arb_en) mode = M_DRAIN;
                M_DRAIN: if (q.size() == 0) mode = M_IDLE;
                default: if (bus.arb_en) mode = M_RUN;
            endcase
        end
        cycle++;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    logic [15:0] tbl [4];
    logic [3:0]  exp3 [4];
    logic [3:0]  e;

    initial begin
        tbl[0] = 16'h1234; tbl[1] = 16'h11CB; tbl[2] = 16'h15CA; tbl[3] = 16'h19C9;
        exp3[0] = 4'b0010; exp3[1] = 4'b1000; exp3[2] = 4'b0010; exp3[3] = 4'b1000;
        bus.arb_en    = 1'b1;
        bus.req_valid = 4'b0000;
        bus.req_addr  = {10'h3FF, 10'h2AA, 10'h155, 10'h000};
        repeat (3) cyc();

        // reset release: WAIT holds off the first grant
        rst_n = 1'b1;
        bus.req_valid = 4'b0001;
        for (int i = 0; i < INIT_CYC; i++) begin
            mid();
            chk("init_no_ready", bus.req_ready, 0);
            cyc();
        end
        mid();
        chk("first_grant", bus.req_ready, 4'b0001);
        for (int i = 0; i < LAT; i++) begin
            cyc();
            mid();
            if (i < LAT - 1) begin
                chk("first_rsp_early", bus.rsp_valid, 0);
            end else begin
                chk("first_rsp_valid", bus.rsp_valid, 4'b0001);
                chk("first_rsp_data", bus.rsp_data, 16'h1234);
            end
        end

        // all four requesting; rr_ptr is 1 after the req0 grants
        for (int k = 0; k < 8 + LAT; k++) begin
            cyc();
            bus.req_valid = (k < 8) ? 4'b1111 : 4'b0000;
            mid();
            e = (k < 8) ? (4'b0001 << ((1 + k) % 4)) : 4'b0000;
            chk("rr_grant", bus.req_ready, e);
            if (k >= LAT) begin
                e = 4'b0001 << ((1 + k - LAT) % 4);
                chk("rr_rsp_valid", bus.rsp_valid, e);
                chk("rr_rsp_data", bus.rsp_data, tbl[(1 + k - LAT) % 4]);
            end
        end

        // sparse pattern 1010 skips invalid requesters
        for (int k = 0; k < 4; k++) begin
            cyc();
            bus.req_valid = (k == 0) ? 4'b0010 : 4'b1010;
            mid();
            chk("sparse_grant", bus.req_ready, exp3[k]);
        end
        for (int k = 0; k < LAT; k++) begin
            cyc();
            bus.req_valid = 4'b0000;
        end

        // arb_en drop with two lookups in flight
        cyc();
        bus.req_valid = 4'b1111;
        mid();
        chk("drain_grant0", bus.req_ready, 4'b0001);
        cyc();
        mid();
        chk("drain_grant1", bus.req_ready, 4'b0010);
        cyc();
        bus.arb_en = 1'b0;
        mid();
        chk("drop_no_grant", bus.req_ready, 0);
        for (int j = 3; j <= LAT + 2; j++) begin
            cyc();
            mid();
            chk("drain_busy", bus.busy, (j <= LAT + 1) ? 1 : 0);
            if (j == LAT + 1) chk("drain_last_rsp", bus.rsp_valid, 4'b0010);
        end
        cyc();
        bus.arb_en = 1'b1;
        mid();
        chk("idle_no_ready", bus.req_ready, 0);
        cyc();
        mid();
        chk("resume_grant", bus.req_ready, 4'b0100);

        // reset pulse mid-burst
        cyc();
        mid();
        cyc();
        rst_n = 1'b0;
        mid();
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < INIT_CYC; i++) begin
            mid();
            chk("rewait_no_ready", bus.req_ready, 0);
            chk("rewait_no_rsp", bus.rsp_valid, 0);
            cyc();
        end
        mid();
        chk("regrant", bus.req_ready, 4'b0001);
        repeat (LAT + 1) cyc();
        bus.req_valid = 4'b0000;
        repeat (LAT + 2) cyc();
        mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
